// File: rtl/tea_block_loader.sv
// Input stage of the TEA datapath: debounces the push-button, assembles v0/v1/k0..k3
// from 24 operator-entered bytes and offers the operand set over a valid/ready handshake.
`timescale 1ns/1ps
module tea_block_loader #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned DB_W            = 18
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        go_n,
  input  logic [7:0]  data_in,
  input  logic        mode_in,
  output logic [31:0] v0,
  output logic [31:0] v1,
  output logic [31:0] k0,
  output logic [31:0] k1,
  output logic [31:0] k2,
  output logic [31:0] k3,
  output logic        mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  byte_idx
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {COLLECT, VALID} state_t;
  state_t state;

  logic            sync1;
  logic            sync2;
  logic            db;
  logic            db_d;
  logic [DB_W-1:0] cnt;
  logic            press;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      db    <= 1'b1;
      db_d  <= 1'b1;
      cnt   <= '0;
    end else begin
      sync1 <= go_n;
      sync2 <= sync1;
      db_d  <= db;
      // Any sample that agrees with the debounced level restarts the stability count.
      if (sync2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db  <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = db_d & ~db;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= COLLECT;
      v0        <= '0;
      v1        <= '0;
      k0        <= '0;
      k1        <= '0;
      k2        <= '0;
      k3        <= '0;
      mode      <= 1'b0;
      out_valid <= 1'b0;
      byte_idx  <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (press) begin
            case (byte_idx[4:2])
              3'd0:    v0 <= {v0[23:0], data_in};
              3'd1:    v1 <= {v1[23:0], data_in};
              3'd2:    k0 <= {k0[23:0], data_in};
              3'd3:    k1 <= {k1[23:0], data_in};
              3'd4:    k2 <= {k2[23:0], data_in};
              3'd5:    k3 <= {k3[23:0], data_in};
              default: ;
            endcase
            if (byte_idx == 5'd23) begin
              mode      <= mode_in;
              byte_idx  <= '0;
              out_valid <= 1'b1;
              state     <= VALID;
            end else begin
              byte_idx <= byte_idx + 5'd1;
            end
          end
        end
        VALID: begin
          // Presses while the operand set is on offer are dropped, not queued.
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_tea_block_loader.sv
// Randomised and directed bench for tea_block_loader, checked every cycle against
// a behavioural model (sliding-window debounce plus byte-stream word assembly).
`timescale 1ns/1ps
module tb_tea_block_loader;

  localparam int unsigned DC = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        go_n;
  logic [7:0]  data_in;
  logic        mode_in;
  logic        out_ready;
  logic [31:0] v0, v1, k0, k1, k2, k3;
  logic        mode;
  logic        out_valid;
  logic [4:0]  byte_idx;

  initial forever #5 clk = ~clk;

  tea_block_loader #(
    .DEBOUNCE_CYCLES(DC),
    .DB_W(3)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .go_n(go_n),
    .data_in(data_in),
    .mode_in(mode_in),
    .v0(v0),
    .v1(v1),
    .k0(k0),
    .k1(k1),
    .k2(k2),
    .k3(k3),
    .mode(mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .byte_idx(byte_idx)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned valid_cycles = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: operand words as an array, button history as a queue.
  logic [31:0] m_w [6];
  int          m_idx;
  bit          m_valid, m_mode, m_db, m_pend, m_live;
  bit          m_hist[$];

  initial begin
    m_live = 0;
    forever begin
      @(posedge clk);
      if (!resetn) begin
        foreach (m_w[i]) m_w[i] = '0;
        m_idx = 0; m_valid = 0; m_mode = 0; m_db = 1; m_pend = 0;
        m_hist.delete();
        repeat (DC + 2) m_hist.push_back(1'b1);
        m_live = 1;
      end else begin
        bit cap;
        bit flip;
        cap = m_pend;
        m_pend = 0;
        if (m_valid) begin
          if (out_ready) m_valid = 0;
        end else if (cap) begin
          m_w[m_idx / 4] = (m_w[m_idx / 4] << 8) | 32'(data_in);
          m_idx++;
          if (m_idx == 24) begin
            m_idx = 0; m_valid = 1; m_mode = mode_in;
          end
        end
        // Level flips once the last DC synchronised samples (go_n two edges late) all disagree.
        flip = 1;
        for (int k = 0; k < int'(DC); k++)
          if (m_hist[m_hist.size() - 2 - k] == m_db) flip = 0;
        if (flip) begin
          m_db = !m_db;
          if (!m_db) m_pend = 1;
        end
        m_hist.push_back(go_n);
        void'(m_hist.pop_front());
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_live) begin
      chk("byte_idx", 64'(byte_idx), 64'(m_idx));
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("mode", 64'(mode), 64'(m_mode));
      chk("v0", 64'(v0), 64'(m_w[0]));
      chk("v1", 64'(v1), 64'(m_w[1]));
      chk("k0", 64'(k0), 64'(m_w[2]));
      chk("k1", 64'(k1), 64'(m_w[3]));
      chk("k2", 64'(k2), 64'(m_w[4]));
      chk("k3", 64'(k3), 64'(m_w[5]));
      if (out_valid) valid_cycles++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_byte(input logic [7:0] d, input logic m);
    data_in = d; mode_in = m; go_n = 1'b0;
    cyc(DC + 4);
    go_n = 1'b1;
    cyc(DC + 4);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cyc(1);
    resetn = 1'b1;
  endtask

  logic [7:0] pat [24];

  initial begin
    for (int i = 0; i < 24; i++)
      pat[i] = (i < 8) ? 8'(8'h01 + i * 8'h22) : 8'((i - 8) * 8'h11);
    resetn = 1'b0; go_n = 1'b1; data_in = '0; mode_in = 1'b0; out_ready = 1'b0;
    cyc(3);
    resetn = 1'b1;
    chk("reset_idx", 64'(byte_idx), 64'd0);
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_v0", 64'(v0), 64'd0);

    // Debounce latency: capture exactly at edge DC+3.
    data_in = 8'hA5; go_n = 1'b0;
    cyc(DC + 2);
    chk("lat_before", 64'(byte_idx), 64'd0);
    cyc(1);
    chk("lat_idx", 64'(byte_idx), 64'd1);
    chk("lat_v0", 64'(v0), 64'h000000A5);
    cyc(4);
    go_n = 1'b1;
    cyc(DC + 4);
    chk("lat_release", 64'(byte_idx), 64'd1);

    // Glitch rejection, then a bounced press.
    data_in = 8'h3C; go_n = 1'b0;
    cyc(3);
    go_n = 1'b1;
    cyc(12);
    chk("glitch_idx", 64'(byte_idx), 64'd1);
    go_n = 1'b0; cyc(3);
    go_n = 1'b1; cyc(1);
    go_n = 1'b0;
    cyc(DC + 2);
    chk("bounce_before", 64'(byte_idx), 64'd1);
    cyc(1);
    chk("bounce_idx", 64'(byte_idx), 64'd2);
    chk("bounce_v0", 64'(v0), 64'h0000A53C);
    cyc(3);
    go_n = 1'b1;
    cyc(DC + 4);
    chk("bounce_once", 64'(byte_idx), 64'd2);

    // Full load, encrypt, core not ready.
    do_reset();
    for (int i = 0; i < 24; i++) press_byte(pat[i], 1'b0);
    chk("load_v0", 64'(v0), 64'h01234567);
    chk("load_v1", 64'(v1), 64'h89ABCDEF);
    chk("load_k0", 64'(k0), 64'h00112233);
    chk("load_k3", 64'(k3), 64'hCCDDEEFF);
    chk("load_valid", 64'(out_valid), 64'd1);
    chk("load_idx", 64'(byte_idx), 64'd0);
    chk("load_mode", 64'(mode), 64'd0);

    // Handshake hold: presses ignored while valid and not ready.
    press_byte(8'hFF, 1'b1);
    press_byte(8'hFF, 1'b1);
    cyc(50 - 4 * (DC + 4));
    chk("hold_v0", 64'(v0), 64'h01234567);
    chk("hold_k3", 64'(k3), 64'hCCDDEEFF);
    chk("hold_valid", 64'(out_valid), 64'd1);
    chk("hold_idx", 64'(byte_idx), 64'd0);
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    chk("xfer_valid", 64'(out_valid), 64'd0);
    chk("xfer_idx", 64'(byte_idx), 64'd0);

    // Reset mid-entry.
    for (int i = 0; i < 10; i++) press_byte(pat[23 - i], 1'b0);
    chk("mid_idx", 64'(byte_idx), 64'd10);
    do_reset();
    chk("rst_v0", 64'(v0), 64'd0);
    chk("rst_v1", 64'(v1), 64'd0);
    chk("rst_k0", 64'(k0), 64'd0);
    chk("rst_idx", 64'(byte_idx), 64'd0);
    cyc(12);
    chk("rst_nopress", 64'(byte_idx), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);

    // Decrypt, ready tied high, back-to-back loads.
    out_ready = 1'b1;
    valid_cycles = 0;
    for (int i = 0; i < 24; i++) press_byte(pat[i], 1'b1);
    chk("b2b1_vcycles", 64'(valid_cycles), 64'd1);
    chk("b2b1_mode", 64'(mode), 64'd1);
    valid_cycles = 0;
    for (int i = 0; i < 24; i++) press_byte(8'(i * 7 + 3), 1'b1);
    chk("b2b2_vcycles", 64'(valid_cycles), 64'd1);
    chk("b2b2_v0", 64'(v0), 64'h030A1118);
    chk("b2b2_k3", 64'(k3), 64'h8F969DA4);

    // Random presses, glitches, readiness and occasional resets.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        do_reset();
      end else begin
        out_ready = 1'($urandom_range(0, 1));
        data_in   = 8'($urandom);
        mode_in   = 1'($urandom_range(0, 1));
        go_n      = 1'b0;
        cyc(int'($urandom_range(1, DC + 5)));
        go_n      = 1'b1;
        cyc(int'($urandom_range(1, DC + 5)));
      end
    end
    cyc(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tea_block_loader.md
# tea_block_loader

Upstream input stage of the FPGA TEA encryption datapath. It debounces the raw active-low push-button and assembles the 64-bit plaintext/ciphertext block (v0, v1) and the 128-bit key (k0..k3) from 24 operator-entered bytes. It then presents the complete 192-bit operand set plus an encrypt/decrypt mode bit to the cipher core over a valid/ready handshake. The cipher core can therefore work with full 32-bit words instead of 10-bit switch values.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 250000: consecutive stable cycles required before the debounced button level changes (5 ms at 50 MHz); legal range ≥ 1.
- DB_W, default 18: width of the debounce counter; must satisfy 2^DB_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock (CLOCK_50).
- resetn  in  1  synchronous, active-low reset.
- go_n  in  1  raw push-button, active-low, asynchronous to clk.
- data_in  in  8  byte value from the switches.
- mode_in  in  1  0 = encrypt, 1 = decrypt; sampled with the 24th byte.
- v0, v1, k0, k1, k2, k3  out  32 each  assembled operand words.
- mode  out  1  registered mode_in.
- out_valid  out  1  operand set complete and stable.
- out_ready  in  1  cipher core accepts the operand set.
- byte_idx  out  5  index of the next byte to be entered, 0..23, for the HEX progress display.

## Operation
- **Synchronizer:** two flops on go_n (sync1, sync2), both reset to 1.
- **Debouncer:** register db resets to 1; counter cnt resets to 0.
  - If sync2 == db: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: db <= sync2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - db_d is db delayed one cycle.
  - press = db_d & ~db, combinational, high for exactly one cycle per debounced falling edge.
  - A release produces no press.
- **FSM states:**
  - COLLECT (reset state), out_valid=0.
    - On press: shift data_in into the word selected by byte_idx[4:2] (0=v0, 1=v1, 2=k0, 3=k1, 4=k2, 5=k3), using word <= {word[23:0], data_in]}. The first byte of each word ends up in bits [31:24] (MSB first).
    - Then byte_idx <= byte_idx+1.
    - On press with byte_idx == 23: capture the byte, set mode <= mode_in, set byte_idx <= 0, and go to VALID.
  - VALID, out_valid=1.
    - All word outputs and mode are held constant.
    - press is ignored and not queued.
    - On out_valid & out_ready: go to COLLECT.
- Word registers are not cleared on return to COLLECT. They are overwritten byte by byte; out_valid=0 marks them as not yet meaningful.
- **Reset values:**
  - v0..k3 = 0, mode = 0, out_valid = 0, byte_idx = 0, state COLLECT.
  - sync1 = sync2 = db = db_d = 1, cnt = 0.
- **Reset mid-entry:** all partial words and the byte index are discarded.
- **Button held across reset release:** this yields one press after the normal debounce latency. That is legal behaviour.
- **Glitches:** a go_n low pulse shorter than DEBOUNCE_CYCLES cycles after synchronization produces no press. Any bounce back to 1 restarts cnt at 0.

## Timing
- Let edge 1 be the first clk edge that samples go_n = 0, with go_n held low.
- sync2 falls at edge 2 and db falls at edge DEBOUNCE_CYCLES+2.
- press is high in the cycle after that edge, so data_in is captured at edge DEBOUNCE_CYCLES+3.
- data_in and mode_in must be stable from edge 1 until the capture edge.
- out_valid rises on the same edge that captures the 24th byte.
- Transfer occurs on any edge with out_valid=1 and out_ready=1.
  - out_valid is 0 the following cycle.
  - Minimum VALID duration is 1 cycle.
  - out_ready may be held high permanently.
- A press whose cycle coincides with the transfer cycle is dropped.
- byte_idx updates on the capture edge; no combinational path from data_in to outputs.

## Test plan
(Run with DEBOUNCE_CYCLES = 4.)
1. **Debounce latency:** reset, then drive go_n low at edge 1 and hold it; data_in = 8'hA5.
   - Required: byte_idx becomes 1 after edge 7; v0 = 32'h000000A5.
   - No further increment while held or on release.
2. **Glitch rejection:** go_n low for 3 sampled cycles, then high; repeat with a 1-cycle high bounce inside an 8-cycle low.
   - Required: the 3-cycle pulse produces no capture.
   - Required: the bounced press produces exactly one capture, 4 stable cycles after the bounce ends.
3. **Full load, encrypt:** enter bytes 01 23 45 67 | 89 AB CD EF | 00 11 22 33 | 44 55 66 77 | 88 99 AA BB | CC DD EE FF with mode_in = 0 and out_ready = 0.
   - Required: v0 = 32'h01234567, v1 = 32'h89ABCDEF, k0 = 32'h00112233, k3 = 32'hCCDDEEFF.
   - Required: out_valid = 1, byte_idx = 0, mode = 0.
4. **Handshake hold:** after test 3, keep out_ready = 0 for 50 cycles while issuing 2 presses with data_in = 8'hFF.
   - Required: outputs unchanged, out_valid stays 1.
   - Then pulse out_ready for 1 cycle. Required: out_valid = 0 on the next cycle and the FSM is in COLLECT with byte_idx = 0.
5. **Reset mid-entry:** after 10 captured bytes, assert resetn = 0 for 1 cycle.
   - Required: all words = 0, byte_idx = 0, out_valid = 0, and no spurious press on reset release.
6. **Decrypt mode and back-to-back:** load 24 bytes with mode_in = 1 and out_ready tied to 1.
   - Required: out_valid is high for exactly 1 cycle and mode = 1.
   - Required: a second 24-byte load then produces a second 1-cycle out_valid with the new words.
